team_06_volume_ramp_scaler: RTL and testbench

Multi-channel audio volume scaler that replaces the single-channel fixed shifter.
- Adds a per-frame valid/ready handshake, a 2-stage pipeline and mute.
- Adds zipper-free gain ramping: the applied gain steps by one LSB toward the target every RAMP_DIV accepted frames.
- Sits between the sample source (decoder/FIFO) and the PWM/DAC output stage.

---
 rtl/team_06_audio_pkg.sv | 43 ++++
 rtl/team_06_gain_ramp.sv | 87 ++++++++
 rtl/team_06_volume_ramp_scaler.sv | 107 ++++++++++
 tb/tb_team_06_volume_ramp_scaler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/team_06_audio_pkg.sv
// Shared types and helpers for the team_06 volume ramp scaler.
//   ramp_state_t  : classification of the applied gain against the target gain
//   SCALE_W       : working width of the per-channel scale helper
//   gain_width()  : width of the gain register for a given volume width
//   scale_sample(): one channel of (sample * gain) >> vol_w, unsigned or signed
package team_06_audio_pkg;

   typedef enum logic [1:0] {
      IDLE,
      UP,
      DOWN
   } ramp_state_t;

   localparam int unsigned SCALE_W = 32;

   // Gain spans 0..2^vol_w inclusive, so it needs one bit more than volume.
   function automatic int unsigned gain_width(input int unsigned vol_w);
      return vol_w + 1;
   endfunction

   // The sample arrives zero-extended in the low data_w bits. In signed mode
   // it is sign-extended here so the arithmetic shift floors toward -inf; in
   // unsigned mode the operand stays non-negative and the shift is logical.
   function automatic logic [SCALE_W-1:0] scale_sample(
      input logic [SCALE_W-1:0] sample,
      input int unsigned        data_w,
      input logic [SCALE_W-1:0] gain,
      input int unsigned        vol_w,
      input logic               is_signed
   );
      logic signed [2*SCALE_W-1:0] s_ext;
      logic signed [2*SCALE_W-1:0] g_ext;
      logic signed [2*SCALE_W-1:0] prod;
      s_ext = {{SCALE_W{1'b0}}, sample};
      if (is_signed && sample[data_w-1]) begin
         s_ext = s_ext - (64'sd1 <<< data_w);
      end
      g_ext = {{SCALE_W{1'b0}}, gain};
      prod  = (s_ext * g_ext) >>> vol_w;
      return SCALE_W'(prod);
   endfunction

endpackage

// File: rtl/team_06_gain_ramp.sv
// Gain ramp controller: walks the applied gain one LSB toward the target
// every RAMP_DIV accepted frames while volume scaling is enabled.
//   clk, rst      : clock, asynchronous active-high reset
//   frame_accept  : a frame is accepted by the datapath this cycle
//   enable        : volume scaling enabled (0 freezes gain and counter)
//   volume, mute  : target = mute ? 0 : volume + 1
//   cur_gain      : applied gain, 0..2^VOL_W
//   ramp_busy     : enable is high and cur_gain differs from target
module team_06_gain_ramp
   import team_06_audio_pkg::*;
#(
   parameter int unsigned VOL_W    = 4,
   parameter int unsigned RAMP_DIV = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_accept,
   input  logic             enable,
   input  logic [VOL_W-1:0] volume,
   input  logic             mute,
   output logic [VOL_W:0]   cur_gain,
   output logic             ramp_busy
);

   localparam int unsigned GAIN_W = gain_width(VOL_W);
   localparam int unsigned CNT_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(RAMP_DIV - 1);

   logic [GAIN_W-1:0] target;
   logic [GAIN_W-1:0] gain_next;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;
   logic              step;
   ramp_state_t       state;

   assign target = mute ? '0 : ({1'b0, volume} + GAIN_W'(1));
   assign step   = frame_accept && enable;

   // State register: the FSM state is fully implied by cur_gain vs. target,
   // so only gain and counter are stored; a target change is seen at once.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_gain <= '0;
         count    <= '0;
      end else begin
         cur_gain <= gain_next;
         count    <= count_next;
      end
   end

   // Next-state: classify, then advance counter / gain. The frame accepted
   // in the step cycle was already snapshotted with the pre-step gain.
   // NOTE: every variable gets a default first so no path infers a latch.
   always_comb begin
      state      = IDLE;
      count_next = count;
      gain_next  = cur_gain;
      if (cur_gain < target) begin
         state = UP;
      end else if (cur_gain > target) begin
         state = DOWN;
      end
      unique case (state)
         IDLE: count_next = '0;
         UP, DOWN: begin
            if (step) begin
               if (count == LAST) begin
                  count_next = '0;
                  gain_next  = (state == UP) ? cur_gain + GAIN_W'(1)
                                             : cur_gain - GAIN_W'(1);
               end else begin
                  count_next = count + CNT_W'(1);
               end
            end
         end
         default: count_next = '0;
      endcase
   end

   // Outputs
   always_comb begin
      ramp_busy = enable && (cur_gain != target);
   end

endmodule

// File: rtl/team_06_volume_ramp_scaler.sv
// Multi-channel volume scaler with valid/ready handshake, 2-stage pipeline,
// mute and zipper-free gain ramping.
//   clk, rst        : clock, asynchronous active-high reset
//   audio_in        : CHANNELS packed samples, channel 0 in the LSBs
//   in_valid/ready  : upstream handshake
//   volume, mute    : target gain control (mute ramps down, never cuts)
//   enable_volume   : 0 = bypass, output equals input, ramp frozen
//   audio_out       : scaled frame, held while out_valid && !out_ready
//   out_valid/ready : downstream handshake
//   ramp_busy       : gain still moving toward target
module team_06_volume_ramp_scaler
   import team_06_audio_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned VOL_W       = 4,
   parameter int unsigned CHANNELS    = 2,
   parameter int unsigned RAMP_DIV    = 16,
   parameter bit          SIGNED_MODE = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [CHANNELS*DATA_W-1:0] audio_in,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [VOL_W-1:0]           volume,
   input  logic                       enable_volume,
   input  logic                       mute,
   output logic [CHANNELS*DATA_W-1:0] audio_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       ramp_busy
);

   localparam int unsigned GAIN_W  = gain_width(VOL_W);
   localparam int unsigned FRAME_W = CHANNELS * DATA_W;

   logic               advance;
   logic               frame_accept;
   logic [GAIN_W-1:0]  cur_gain;

   logic               s1_valid;
   logic               s1_bypass;
   logic [FRAME_W-1:0] s1_data;
   logic [GAIN_W-1:0]  s1_gain;
   logic [FRAME_W-1:0] s2_data_next;

   // The whole pipe moves together; it only stalls when the output is full
   // and downstream refuses it.
   assign advance      = !out_valid || out_ready;
   assign in_ready     = advance;
   assign frame_accept = in_valid && advance;

   team_06_gain_ramp #(
      .VOL_W   (VOL_W),
      .RAMP_DIV(RAMP_DIV)
   ) u_ramp (
      .clk         (clk),
      .rst         (rst),
      .frame_accept(frame_accept),
      .enable      (enable_volume),
      .volume      (volume),
      .mute        (mute),
      .cur_gain    (cur_gain),
      .ramp_busy   (ramp_busy)
   );

   // Stage 1: sample, gain snapshot and bypass flag travel together so a
   // later gain step or enable change cannot affect a frame in flight.
   // NOTE: datapath registers are reset as well, so audio_out reads zero
   // immediately after reset and no stale frame can leak out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_bypass <= 1'b0;
         s1_data   <= '0;
         s1_gain   <= '0;
      end else if (advance) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data   <= audio_in;
            s1_gain   <= cur_gain;
            s1_bypass <= !enable_volume;
         end
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign s2_data_next[c*DATA_W +: DATA_W] = s1_bypass
         ? s1_data[c*DATA_W +: DATA_W]
         : DATA_W'(scale_sample(SCALE_W'(s1_data[c*DATA_W +: DATA_W]), DATA_W,
                                SCALE_W'(s1_gain), VOL_W, SIGNED_MODE));
   end

   // Stage 2: output register; data only reloads for a valid frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         audio_out <= '0;
      end else if (advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            audio_out <= s2_data_next;
         end
      end
   end

endmodule

// File: tb/tb_team_06_volume_ramp_scaler.sv
// Bench for team_06_volume_ramp_scaler: a frame-level reference model checks
// the unsigned instance every cycle; directed literal checks pin the model
// and cover the signed instance.
module tb_team_06_volume_ramp_scaler;

   localparam int DATA_W   = 8;
   localparam int VOL_W    = 4;
   localparam int CHANNELS = 2;
   localparam int RAMP_DIV = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [15:0] audio_in = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  volume = '0;
   logic        enable_volume = 1'b0;
   logic        mute = 1'b0;
   logic [15:0] audio_out;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        ramp_busy;

   logic [15:0] s_audio_in = '0;
   logic        s_in_valid = 1'b0;
   logic        s_in_ready;
   logic [3:0]  s_volume = '0;
   logic        s_enable = 1'b0;
   logic        s_mute = 1'b0;
   logic [15:0] s_audio_out;
   logic        s_out_valid;
   logic        s_out_ready = 1'b1;
   logic        s_ramp_busy;

   int total = 0;
   int bad   = 0;

   int          m_gain, m_cnt, accepts, transfers;
   bit          m_p1_v, m_p2_v;
   logic [15:0] m_p1_d, m_p2_d;
   logic [15:0] out_log[$];

   always #5 clk = ~clk;

   team_06_volume_ramp_scaler #(
      .DATA_W(DATA_W), .VOL_W(VOL_W), .CHANNELS(CHANNELS),
      .RAMP_DIV(RAMP_DIV), .SIGNED_MODE(1'b0)
   ) dut_u (
      .clk(clk), .rst(rst), .audio_in(audio_in), .in_valid(in_valid),
      .in_ready(in_ready), .volume(volume), .enable_volume(enable_volume),
      .mute(mute), .audio_out(audio_out), .out_valid(out_valid),
      .out_ready(out_ready), .ramp_busy(ramp_busy)
   );

   team_06_volume_ramp_scaler #(
      .DATA_W(DATA_W), .VOL_W(VOL_W), .CHANNELS(CHANNELS),
      .RAMP_DIV(RAMP_DIV), .SIGNED_MODE(1'b1)
   ) dut_s (
      .clk(clk), .rst(rst), .audio_in(s_audio_in), .in_valid(s_in_valid),
      .in_ready(s_in_ready), .volume(s_volume), .enable_volume(s_enable),
      .mute(s_mute), .audio_out(s_audio_out), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .ramp_busy(s_ramp_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Expected unsigned output frame: plain integer scaling per channel.
   function automatic logic [15:0] expect_frame(input logic [15:0] f, input int g, input bit byp);
      logic [15:0] r;
      int s;
      r = '0;
      for (int c = 0; c < 2; c++) begin
         s = int'(f[c*8 +: 8]);
         r[c*8 +: 8] = byp ? 8'(s) : 8'((s * g) / 16);
      end
      return r;
   endfunction

   // Reference model + per-cycle compare for the unsigned instance.
   always @(negedge clk) begin : model
      bit adv, acc;
      int tgt;
      if (rst) begin
         m_gain = 0;
         m_cnt  = 0;
         m_p1_v = 1'b0;
         m_p2_v = 1'b0;
         m_p1_d = '0;
         m_p2_d = '0;
      end else begin
         tgt = mute ? 0 : int'(volume) + 1;
         check("out_valid", 32'(out_valid), 32'(m_p2_v));
         if (m_p2_v) check("audio_out", 32'(audio_out), 32'(m_p2_d));
         check("in_ready", 32'(in_ready), 32'(!m_p2_v || out_ready));
         check("cur_gain", 32'(dut_u.u_ramp.cur_gain), 32'(m_gain));
         check("ramp_count", 32'(dut_u.u_ramp.count), 32'(m_cnt));
         check("ramp_busy", 32'(ramp_busy), 32'(enable_volume && (m_gain != tgt)));
         if (out_valid && out_ready) begin
            out_log.push_back(audio_out);
            transfers++;
         end
         adv = !m_p2_v || out_ready;
         acc = in_valid && adv;
         if (adv) begin
            if (m_p1_v) m_p2_d = m_p1_d;
            m_p2_v = m_p1_v;
            m_p1_v = in_valid;
            if (in_valid) m_p1_d = expect_frame(audio_in, m_gain, !enable_volume);
         end
         if (m_gain == tgt) begin
            m_cnt = 0;
         end else if (acc && enable_volume) begin
            if (m_cnt == RAMP_DIV - 1) begin
               m_cnt  = 0;
               m_gain = m_gain + ((tgt > m_gain) ? 1 : -1);
            end else begin
               m_cnt++;
            end
         end
         if (acc) accepts++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] held;
      int          saved_cnt;

      tick();
      tick();
      rst = 1'b0;

      // 1. Bypass
      enable_volume = 1'b0;
      volume        = 4'd15;
      in_valid      = 1'b1;
      audio_in      = {8'd200, 8'd64};
      tick();
      in_valid = 1'b0;
      check("byp_not_yet_valid", 32'(out_valid), 32'd0);
      tick();
      check("byp_valid", 32'(out_valid), 32'd1);
      check("byp_data", 32'(audio_out), 32'h0000_C840);
      check("byp_gain", 32'(dut_u.u_ramp.cur_gain), 32'd0);

      // 2. Ramp up from reset
      pulse_reset();
      out_log.delete();
      enable_volume = 1'b1;
      volume        = 4'd15;
      in_valid      = 1'b1;
      audio_in      = {8'd128, 8'd128};
      repeat (70) tick();
      in_valid = 1'b0;
      repeat (3) tick();
      check("ramp_log_size", 32'(out_log.size()), 32'd70);
      if (out_log.size() >= 70) begin
         check("ramp_f0", 32'(out_log[0]), 32'h0000);
         check("ramp_f3", 32'(out_log[3]), 32'h0000);
         check("ramp_f4", 32'(out_log[4]), 32'h0808);
         check("ramp_f7", 32'(out_log[7]), 32'h0808);
         check("ramp_f8", 32'(out_log[8]), 32'h1010);
         check("ramp_f63", 32'(out_log[63]), 32'h7878);
         check("ramp_f64", 32'(out_log[64]), 32'h8080);
         check("ramp_f69", 32'(out_log[69]), 32'h8080);
      end
      check("ramp_gain16", 32'(dut_u.u_ramp.cur_gain), 32'd16);
      check("ramp_busy_low", 32'(ramp_busy), 32'd0);

      // 3. Steady state at volume 6, then mute ramp-down
      volume   = 4'd6;
      audio_in = {8'd255, 8'd64};
      in_valid = 1'b1;
      repeat (50) tick();
      check("steady_out", 32'(out_log[$]), 32'h0000_6F1C);
      check("steady_gain", 32'(dut_u.u_ramp.cur_gain), 32'd7);
      mute = 1'b1;
      repeat (32) tick();
      check("mute_out", 32'(out_log[$]), 32'h0000);
      check("mute_gain", 32'(dut_u.u_ramp.cur_gain), 32'd0);
      check("mute_busy", 32'(ramp_busy), 32'd0);
      in_valid = 1'b0;
      mute     = 1'b0;

      // 4. Backpressure mid-ramp, then reset mid-stream
      pulse_reset();
      accepts   = 0;
      transfers = 0;
      volume    = 4'd15;
      in_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         audio_in = {8'(i * 13 + 7), 8'(i * 29 + 3)};
         tick();
      end
      out_ready = 1'b0;
      #1;
      held      = audio_out;
      saved_cnt = int'(dut_u.u_ramp.count);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         audio_in = {8'(i * 5 + 100), 8'(i * 11 + 50)};
         tick();
         check("bp_hold", 32'(audio_out), 32'(held));
         check("bp_valid", 32'(out_valid), 32'd1);
      end
      check("bp_count_frozen", 32'(dut_u.u_ramp.count), 32'(saved_cnt));
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         audio_in = {8'(i * 17 + 1), 8'(i * 23 + 9)};
         tick();
      end
      in_valid = 1'b0;
      repeat (4) tick();
      check("bp_no_loss", 32'(transfers), 32'(accepts));
      check("bp_accepts", 32'(accepts), 32'd20);

      in_valid = 1'b1;
      repeat (3) tick();
      check("rst_pre_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(audio_out), 32'd0);
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;

      // 5. Reversal mid-count
      pulse_reset();
      volume   = 4'd15;
      audio_in = {8'd100, 8'd50};
      in_valid = 1'b1;
      repeat (22) tick();
      check("rev_gain5", 32'(dut_u.u_ramp.cur_gain), 32'd5);
      check("rev_cnt2", 32'(dut_u.u_ramp.count), 32'd2);
      mute = 1'b1;
      tick();
      check("rev_gain_hold", 32'(dut_u.u_ramp.cur_gain), 32'd5);
      tick();
      check("rev_gain4", 32'(dut_u.u_ramp.cur_gain), 32'd4);
      repeat (16) tick();
      check("rev_gain0", 32'(dut_u.u_ramp.cur_gain), 32'd0);
      check("rev_busy", 32'(ramp_busy), 32'd0);
      mute     = 1'b0;
      in_valid = 1'b0;

      // 6. Signed mode at g=8
      pulse_reset();
      s_enable   = 1'b1;
      s_volume   = 4'd7;
      s_in_valid = 1'b1;
      s_audio_in = '0;
      repeat (32) tick();
      check("sgn_gain8", 32'(dut_s.u_ramp.cur_gain), 32'd8);
      s_audio_in = {8'hFF, 8'h80};
      tick();
      s_audio_in = {8'h7F, 8'h7F};
      tick();
      s_in_valid = 1'b0;
      check("sgn_valid", 32'(s_out_valid), 32'd1);
      check("sgn_neg", 32'(s_audio_out), 32'h0000_FFC0);
      tick();
      check("sgn_pos", 32'(s_audio_out), 32'h0000_3F3F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
